freq_divider_prog: RTL and testbench

Runtime-programmable clock divider. Generalises the fixed divide-by-2 toggle to divide-by-N with a WIDTH-bit divisor. Produces a near-50% divided square wave plus a one-cycle tick enable. Divisor changes are glitch-free: a new divisor takes effect only at a period boundary. Sits between the board clock and slow logic such as debouncers, display scanners and blinkers.

---
 rtl/freq_div_pkg.sv | 17 +
 rtl/freq_div_counter.sv | 44 ++++
 rtl/freq_divider_prog.sv | 81 ++++++++
 tb/tb_freq_divider_prog.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/freq_div_pkg.sv
// Shared constants and divisor helpers for the programmable clock divider.
package freq_div_pkg;

  localparam int unsigned MIN_DIV        = 2;
  localparam int unsigned PERIOD_COUNT_W = 16;

  // Divisors below MIN_DIV run as divide-by-MIN_DIV.
  function automatic int unsigned eff_div(input int unsigned d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

  // First count value of the high phase; low phase gets the odd extra cycle.
  function automatic int unsigned high_start(input int unsigned n);
    return n - (n >> 1);
  endfunction

endpackage

// File: rtl/freq_div_counter.sv
// Period counter for freq_divider_prog: holds cnt and derives wrap, last-cycle and
// output-level decodes for the value cnt takes on the next edge.
module freq_div_counter
  import freq_div_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] div,
  output logic             wrap,
  output logic             cnt_is_last,
  output logic             out_level
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] n_eff, last, hi_start;
  logic             at_last;

  always_comb begin
    n_eff    = WIDTH'(eff_div(32'(div)));
    hi_start = WIDTH'(high_start(eff_div(32'(div))));
    last     = n_eff - WIDTH'(1);
    at_last  = (cnt_q == last);
    wrap     = enable && at_last;
    cnt_d    = cnt_q;
    if (enable) begin
      cnt_d = at_last ? '0 : cnt_q + WIDTH'(1);
    end
    // After a wrap cnt_d is 0, which decodes identically under old or new divisor.
    cnt_is_last = (cnt_d == last);
    out_level   = (cnt_d >= hi_start);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/freq_divider_prog.sv
// Runtime-programmable divide-by-N clock divider with glitch-free divisor reload.
// Define FREQ_DIV_PERIOD_COUNT_EN to add the 16-bit period_count output.
module freq_divider_prog
  import freq_div_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [WIDTH-1:0]          div_in,
  input  logic                      div_load,
  output logic                      div_pending,
  output logic                      out_clock,
  output logic                      tick
`ifdef FREQ_DIV_PERIOD_COUNT_EN
  ,
  output logic [PERIOD_COUNT_W-1:0] period_count
`endif
);

  logic [WIDTH-1:0] active_q, active_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             div_pending_d;
  logic             wrap, cnt_is_last, out_level;

  freq_div_counter #(
    .WIDTH(WIDTH)
  ) u_counter (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .div        (active_q),
    .wrap       (wrap),
    .cnt_is_last(cnt_is_last),
    .out_level  (out_level)
  );

  // A load on the wrap edge lands in pending after the old pending is applied.
  always_comb begin
    active_d      = active_q;
    pending_d     = pending_q;
    div_pending_d = div_pending;
    if (wrap && div_pending) begin
      active_d      = pending_q;
      div_pending_d = 1'b0;
    end
    if (div_load) begin
      pending_d     = div_in;
      div_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      active_q    <= WIDTH'(DEFAULT_DIV);
      pending_q   <= '0;
      div_pending <= 1'b0;
      out_clock   <= 1'b0;
      tick        <= 1'b0;
    end else begin
      active_q    <= active_d;
      pending_q   <= pending_d;
      div_pending <= div_pending_d;
      out_clock   <= out_level;
      tick        <= enable && cnt_is_last;
    end
  end

`ifdef FREQ_DIV_PERIOD_COUNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      period_count <= '0;
    end else if (wrap) begin
      period_count <= period_count + PERIOD_COUNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_freq_divider_prog.sv
// Self-checking bench for freq_divider_prog: directed scenarios plus random traffic,
// all compared against a cycle-level phase/period reference model.
module tb_freq_divider_prog;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] div_in;
  logic       div_load;
  logic       div_pending;
  logic       out_clock;
  logic       tick;
`ifdef FREQ_DIV_PERIOD_COUNT_EN
  logic [15:0] period_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: position within the period, divisors, period count.
  int m_p, m_act, m_pend, m_periods;
  bit m_pf, m_out, m_tick;

  always #5 clock = ~clock;

  freq_divider_prog #(
    .WIDTH      (8),
    .DEFAULT_DIV(2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .div_in      (div_in),
    .div_load    (div_load),
    .div_pending (div_pending),
    .out_clock   (out_clock),
    .tick        (tick)
`ifdef FREQ_DIV_PERIOD_COUNT_EN
    ,
    .period_count(period_count)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int neff(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  task automatic model_reset();
    m_p = 0; m_act = 2; m_pend = 0; m_pf = 0; m_periods = 0; m_out = 0; m_tick = 0;
  endtask

  task automatic compare_all();
    check_eq("out_clock", {31'd0, out_clock}, {31'd0, m_out});
    check_eq("tick", {31'd0, tick}, {31'd0, m_tick});
    check_eq("div_pending", {31'd0, div_pending}, {31'd0, m_pf});
`ifdef FREQ_DIV_PERIOD_COUNT_EN
    check_eq("period_count", {16'd0, period_count}, m_periods & 32'hFFFF);
`endif
  endtask

  // Drive one cycle of inputs, advance the model at the edge, compare on the falling edge.
  task automatic step(input bit en, input bit ld, input int din);
    int n;
    enable = en; div_load = ld; div_in = din[7:0];
    @(posedge clock);
    if (en) begin
      n = neff(m_act);
      if (m_p == n - 1) begin
        m_p = 0;
        m_periods++;
        if (m_pf) begin m_act = m_pend; m_pf = 0; end
      end else begin
        m_p++;
      end
    end
    if (ld) begin m_pend = din & 255; m_pf = 1; end
    n = neff(m_act);
    m_out  = (m_p >= (n + 1) / 2);
    m_tick = en && (m_p == n - 1);
    @(negedge clock);
    div_load = 1'b0;
    compare_all();
  endtask

  task automatic run_until_pos(input int target);
    for (int i = 0; i < 300; i++) begin
      if (m_p == target) break;
      step(1, 0, 0);
    end
    check_eq("reach_pos", m_p, target);
  endtask

  task automatic run_until_applied();
    for (int i = 0; i < 300; i++) begin
      if (!m_pf) break;
      step(1, 0, 0);
    end
    check_eq("applied", {31'd0, m_pf}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; div_in = '0; div_load = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    check_eq("rst_out", {31'd0, out_clock}, 32'd0);
    check_eq("rst_tick", {31'd0, tick}, 32'd0);
    check_eq("rst_pend", {31'd0, div_pending}, 32'd0);
    reset = 1'b0;

    // Legacy divide-by-2 toggle.
    step(1, 0, 0);
    check_eq("first_edge", {31'd0, out_clock}, 32'd1);
    check_eq("first_tick", {31'd0, tick}, 32'd1);
    repeat (3) step(1, 0, 0);

    // Load 5 mid-period.
    run_until_pos(0);
    step(1, 1, 5);
    check_eq("pend_after_load", {31'd0, div_pending}, 32'd1);
    repeat (12) step(1, 0, 0);

    // Two loads in one period: only the last is applied.
    run_until_pos(0);
    step(1, 1, 6);
    step(1, 1, 9);
    run_until_applied();
    check_eq("active_is_9", m_act, 32'd9);
    repeat (20) step(1, 0, 0);

    // Divisors 0 and 1 act as divide-by-2.
    step(1, 1, 0);
    run_until_applied();
    repeat (6) step(1, 0, 0);
    step(1, 1, 1);
    run_until_applied();
    repeat (6) step(1, 0, 0);

    // Freeze at cnt=2 with Neff=5.
    step(1, 1, 5);
    run_until_applied();
    run_until_pos(2);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0);
      check_eq("tick_frozen", {31'd0, tick}, 32'd0);
    end
    step(1, 0, 0);
    check_eq("resume_pos", m_p, 32'd3);
    repeat (8) step(1, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      bit en, ld;
      int d;
      en = ($urandom % 8) != 0;
      ld = en && (($urandom % 10) == 0);
      d  = (($urandom % 4) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
      step(en, ld, d);
    end

    // Async reset mid-period with a divisor pending.
    step(1, 1, 5);
    run_until_applied();
    run_until_pos(1);
    step(1, 1, 9);
    step(1, 0, 0);
    check_eq("pre_rst_out", {31'd0, out_clock}, 32'd1);
    check_eq("pre_rst_pend", {31'd0, div_pending}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_out", {31'd0, out_clock}, 32'd0);
    check_eq("arst_tick", {31'd0, tick}, 32'd0);
    check_eq("arst_pend", {31'd0, div_pending}, 32'd0);
`ifdef FREQ_DIV_PERIOD_COUNT_EN
    check_eq("arst_pcount", {16'd0, period_count}, 32'd0);
`endif
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (6) step(1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
